// File: rtl/pantalla_pkg.sv
// Shared types and constants for the pantalla command sequencer.
// Frames are SYNC, CMD, DATA, CHK with CHK = CMD ^ DATA.
package pantalla_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        DATA,
        CHK,
        WRITE,
        CLEAR
    } state_t;

    localparam logic [3:0] OP_LEDS = 4'h1;
    localparam logic [3:0] OP_WREG = 4'h2;
    localparam logic [3:0] OP_CLR  = 4'h3;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hAA;
    localparam int         BAUD_DIV          = 434;

endpackage

// File: rtl/pantalla_rx_timeout.sv
// Inter-byte watchdog: reloads on every received byte, counts down while a
// frame is open and strobes expired once the full interval has elapsed.
module pantalla_rx_timeout #(
    parameter int TIMEOUT = 100000,
    parameter int TO_W    = 17
) (
    input  logic clkM,
    input  logic rstM,
    input  logic load,
    input  logic en,
    output logic expired
);

    logic [TO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = TO_W'(TIMEOUT);
        end else if (!en) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign expired = en && !load && (cnt_q == '0);

    always_ff @(posedge clkM or posedge rstM) begin
        if (rstM) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pantalla_cmd_ctrl.sv
// Parses framed UART commands and sequences LED / display register writes
// through a req/ack handshake; reports frame outcome and counts errors.
module pantalla_cmd_ctrl
    import pantalla_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT   = 100000,
    parameter int         TO_W      = 17,
    parameter int         NREGS     = 16
) (
    input  logic       clkM,
    input  logic       rstM,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_err,
    output logic       wr_req,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic       wr_ack,
    output logic [7:0] leds,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [7:0] err_cnt,
    output logic       busy
);

    localparam logic [3:0] LAST_ADDR = 4'(NREGS - 1);

    state_t     state_q, state_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] data_q, data_d;
    logic [7:0] leds_q, leds_d;
    logic       wr_req_q, wr_req_d;
    logic [3:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       frame_ok_q, frame_ok_d;
    logic       frame_err_q, frame_err_d;
    logic       err_pend_q, err_pend_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       ok_ev, err_ev;
    logic       to_en, to_expired;

    assign to_en = (state_q == CMD) || (state_q == DATA) || (state_q == CHK);

    pantalla_rx_timeout #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clkM    (clkM),
        .rstM    (rstM),
        .load    (rx_valid),
        .en      (to_en),
        .expired (to_expired)
    );

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        data_d    = data_q;
        leds_d    = leds_q;
        wr_req_d  = wr_req_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        ok_ev     = 1'b0;
        err_ev    = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_valid && !rx_err && rx_data == SYNC_BYTE) state_d = CMD;
            end
            CMD, DATA, CHK: begin
                if (rx_err) begin
                    err_ev  = 1'b1;
                    state_d = IDLE;
                end else if (rx_valid) begin
                    if (state_q == CMD) begin
                        cmd_d   = rx_data;
                        state_d = DATA;
                    end else if (state_q == DATA) begin
                        data_d  = rx_data;
                        state_d = CHK;
                    end else begin
                        state_d = IDLE;
                        if (rx_data != (cmd_q ^ data_q)) begin
                            err_ev = 1'b1;
                        end else begin
                            case (cmd_q[7:4])
                                OP_LEDS: begin
                                    leds_d = data_q;
                                    ok_ev  = 1'b1;
                                end
                                OP_WREG: begin
                                    state_d   = WRITE;
                                    wr_addr_d = cmd_q[3:0];
                                    wr_data_d = data_q;
                                end
                                OP_CLR: begin
                                    state_d   = CLEAR;
                                    wr_addr_d = '0;
                                    wr_data_d = '0;
                                end
                                default: err_ev = 1'b1;
                            endcase
                        end
                    end
                end else if (to_expired) begin
                    err_ev  = 1'b1;
                    state_d = IDLE;
                end
            end
            WRITE, CLEAR: begin
                // Bytes arriving mid-operation are dropped but still reported.
                if (rx_valid) err_ev = 1'b1;
                if (!wr_req_q) begin
                    wr_req_d = 1'b1;
                end else if (wr_ack) begin
                    wr_req_d = 1'b0;
                    if (state_q == WRITE || wr_addr_q == LAST_ADDR) begin
                        ok_ev   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        wr_addr_d = wr_addr_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A drop that coincides with completion is reported one cycle later,
        // when the controller is already idle and cannot raise another event.
        frame_ok_d  = ok_ev;
        frame_err_d = err_pend_q || (err_ev && !ok_ev);
        err_pend_d  = err_ev && ok_ev;
        err_cnt_d   = err_cnt_q;
        if (frame_err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clkM or posedge rstM) begin
        if (rstM) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            data_q      <= '0;
            leds_q      <= '0;
            wr_req_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_pend_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            leds_q      <= leds_d;
            wr_req_q    <= wr_req_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_pend_q  <= err_pend_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign wr_req    = wr_req_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign leds      = leds_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_cnt   = err_cnt_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_pantalla_cmd_ctrl.sv
// Directed and randomized frames against a frame-level reference model.
// Timeout is scaled down so the whole run stays short.
module tb_pantalla_cmd_ctrl;

    localparam int TIMEOUT = 300;
    localparam int NREGS   = 16;

    logic       clkM = 1'b0;
    logic       rstM = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       rx_err = 1'b0;
    logic       wr_req;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ack = 1'b0;
    logic [7:0] leds;
    logic       frame_ok, frame_err;
    logic [7:0] err_cnt;
    logic       busy;

    pantalla_cmd_ctrl #(
        .SYNC_BYTE (8'hAA),
        .TIMEOUT   (TIMEOUT),
        .TO_W      (9),
        .NREGS     (NREGS)
    ) dut (
        .clkM      (clkM),
        .rstM      (rstM),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_err    (rx_err),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .leds      (leds),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_cnt   (err_cnt),
        .busy      (busy)
    );

    initial forever #5 clkM = ~clkM;

    int n_chk = 0;
    int n_fail = 0;

    // reference model state
    logic [7:0]  m_leds = '0;
    int          m_err = 0;
    int          m_ok = 0;
    int          m_errp = 0;
    logic [11:0] exp_wq[$];

    // observed activity
    logic [11:0] wq[$];
    int          ok_seen = 0;
    int          err_seen = 0;
    int          ack_dly = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clkM);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic model_err();
        m_errp++;
        if (m_err < 255) m_err++;
    endtask

    task automatic model_frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k);
        logic [3:0] op;
        op = c[7:4];
        if (k != (c ^ d) || op < 4'd1 || op > 4'd3) begin
            model_err();
        end else begin
            m_ok++;
            if (op == 4'd1) m_leds = d;
            else if (op == 4'd2) exp_wq.push_back({c[3:0], d});
            else for (int a = 0; a < NREGS; a++) exp_wq.push_back({4'(a), 8'h00});
        end
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k, input int gap);
        send_byte(8'hAA, gap);
        send_byte(c, gap);
        send_byte(d, gap);
        send_byte(k, 0);
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n = 0;
        while (busy && n < bound) begin
            tick();
            n++;
        end
        chk(tag, busy, 0);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_leds"}, leds, m_leds);
        chk({tag, "_errcnt"}, err_cnt, m_err);
        chk({tag, "_okcount"}, ok_seen, m_ok);
        chk({tag, "_errpulses"}, err_seen, m_errp);
        chk({tag, "_nwrites"}, wq.size(), exp_wq.size());
        for (int i = 0; i < wq.size() && i < exp_wq.size(); i++)
            chk({tag, "_write"}, wq[i], exp_wq[i]);
        wq.delete();
        exp_wq.delete();
    endtask

    // write acknowledger: acks after ack_dly cycles of held request
    initial begin
        int age = 0;
        forever begin
            @(negedge clkM);
            wr_ack = 1'b0;
            if (wr_req && !rstM) begin
                if (age >= ack_dly) begin
                    wr_ack = 1'b1;
                    wq.push_back({wr_addr, wr_data});
                    age = 0;
                end else begin
                    age++;
                end
            end else begin
                age = 0;
            end
        end
    end

    // pulse counting and handshake invariants
    initial begin
        logic        p_req = 1'b0;
        logic        p_ack = 1'b0;
        logic [11:0] p_ad = '0;
        forever begin
            @(negedge clkM);
            #2;
            if (frame_ok) ok_seen++;
            if (frame_err) err_seen++;
            if (frame_ok || frame_err) chk("ok_err_exclusive", frame_ok & frame_err, 0);
            if (p_ack) chk("req_gap_after_ack", wr_req, 0);
            else if (p_req && wr_req) chk("req_stable", {wr_addr, wr_data}, p_ad);
            p_req = wr_req;
            p_ack = wr_ack;
            p_ad  = {wr_addr, wr_data};
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] c, d, k, noise;
        int gap;

        // reset state
        repeat (3) tick();
        chk("rst_wr_req", wr_req, 0);
        chk("rst_leds", leds, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {frame_ok, frame_err}, 0);
        rstM = 1'b0;
        tick();

        // LED write
        send_frame(8'h10, 8'h5A, 8'h4A, 20);
        model_frame(8'h10, 8'h5A, 8'h4A);
        chk("led_value", leds, 8'h5A);
        chk("led_frame_ok", frame_ok, 1);
        chk("led_err_cnt", err_cnt, 0);
        tick();
        check_model("led");

        // register write, ack after three request cycles
        ack_dly = 3;
        send_frame(8'h27, 8'hC3, 8'hE4, 20);
        model_frame(8'h27, 8'hC3, 8'hE4);
        n = 0;
        while (!wr_req && n < 10) begin tick(); n++; end
        chk("wreg_req_delay", n, 1);
        chk("wreg_addr", wr_addr, 4'h7);
        chk("wreg_data", wr_data, 8'hC3);
        n = 0;
        while (!wr_ack && n < 20) begin tick(); n++; end
        chk("wreg_ack_wait", n, 3);
        chk("wreg_req_at_ack", wr_req, 1);
        tick();
        chk("wreg_frame_ok", frame_ok, 1);
        chk("wreg_req_drop", wr_req, 0);
        tick();
        check_model("wreg");

        // bad checksum
        send_frame(8'h10, 8'h5A, 8'h00, 20);
        model_frame(8'h10, 8'h5A, 8'h00);
        chk("badchk_frame_err", frame_err, 1);
        chk("badchk_leds", leds, 8'h5A);
        chk("badchk_err_cnt", err_cnt, 1);
        tick();
        check_model("badchk");

        // clear with a stray byte mid-operation
        ack_dly = 1;
        send_frame(8'h30, 8'h00, 8'h30, 20);
        model_frame(8'h30, 8'h00, 8'h30);
        repeat (5) tick();
        chk("clr_busy_mid", busy, 1);
        send_byte(8'h55, 0);
        model_err();
        wait_idle("clr_done", 200);
        repeat (2) tick();
        check_model("clear");
        chk("clr_err_cnt", err_cnt, 2);

        // inter-byte timeout
        send_byte(8'hAA, 0);
        send_byte(8'h10, 0);
        repeat (TIMEOUT + 5) tick();
        model_err();
        chk("timeout_idle", busy, 0);
        check_model("timeout");

        // framing error after sync
        send_byte(8'hAA, 0);
        rx_err = 1'b1;
        tick();
        rx_err = 1'b0;
        model_err();
        chk("rxerr_frame_err", frame_err, 1);
        tick();
        check_model("rxerr");

        // reset while a write is outstanding
        ack_dly = 100000;
        send_frame(8'h25, 8'h11, 8'h34, 3);
        n = 0;
        while (!wr_req && n < 10) begin tick(); n++; end
        chk("rstw_req_up", wr_req, 1);
        rstM = 1'b1;
        #1;
        chk("rstw_wr_req", wr_req, 0);
        chk("rstw_addr_data", {wr_addr, wr_data}, 0);
        chk("rstw_leds", leds, 0);
        chk("rstw_err_cnt", err_cnt, 0);
        chk("rstw_busy", busy, 0);
        tick();
        rstM = 1'b0;
        m_leds = '0;
        m_err = 0;
        wq.delete();
        exp_wq.delete();
        ack_dly = 0;
        tick();
        send_frame(8'h10, 8'hFF, 8'hEF, 2);
        model_frame(8'h10, 8'hFF, 8'hEF);
        chk("post_rst_leds", leds, 8'hFF);
        tick();
        check_model("post_rst");

        // randomized frames
        for (int f = 0; f < 40; f++) begin
            ack_dly = $urandom_range(0, 3);
            gap = $urandom_range(0, 4);
            noise = 8'($urandom);
            if (noise == 8'hAA) noise = 8'hAB;
            send_byte(noise, 1);
            c = {4'($urandom_range(0, 4)), 4'($urandom)};
            d = 8'($urandom);
            k = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (c ^ d);
            send_frame(c, d, k, gap);
            model_frame(c, d, k);
            if ((c[7:4] == 4'd2 || c[7:4] == 4'd3) && k == (c ^ d) && $urandom_range(0, 1) == 1) begin
                send_byte(8'h5B, 0);
                model_err();
            end
            wait_idle("rand_idle", 200);
            repeat (2) tick();
            check_model("rand");
        end

        // error counter saturation; odd rounds carry a byte alongside rx_err
        for (int i = 0; i < 260; i++) begin
            send_byte(8'hAA, 0);
            rx_err = 1'b1;
            rx_valid = i[0];
            rx_data = 8'h3C;
            tick();
            rx_err = 1'b0;
            rx_valid = 1'b0;
            model_err();
        end
        tick();
        chk("sat_err_cnt", err_cnt, 8'hFF);
        check_model("sat");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
